// File: rtl/dmem_pkg.sv
// Shared definitions for the RV32 load/store data memory: funct3 codes, FSM states,
// the load context carried from accept to response, and the byte-enable generator.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [2:0] funct3;
    logic [1:0] lane;
  } ld_ctx_t;

  // Lane mask for an access of the given size starting at the given lane
  function automatic logic [3:0] be_gen(input logic [2:0] funct3, input logic [1:0] lane);
    case (funct3)
      F3_B, F3_BU: be_gen = 4'(4'b0001 << lane);
      F3_H, F3_HU: be_gen = 4'(4'b0011 << lane);
      F3_W:        be_gen = 4'b1111;
      default:     be_gen = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bank.sv
// Word-organised RAM with per-byte write enables and a registered read address.
module dmem_bank #(
  parameter int unsigned WORD_AW = 8
) (
  input  logic               clk,
  input  logic [3:0]         we,
  input  logic [WORD_AW-1:0] waddr,
  input  logic [31:0]        wdata,
  input  logic               re,
  input  logic [WORD_AW-1:0] raddr,
  output logic [31:0]        rdata
);

  localparam int unsigned DEPTH = 2 ** WORD_AW;

  logic [31:0]        mem [DEPTH];
  logic [WORD_AW-1:0] raddr_q;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    if (re) raddr_q <= raddr;
  end

  assign rdata = mem[raddr_q];

endmodule

// File: rtl/data_memory_lsu.sv
// RV32 load/store unit in front of a byte-lane data RAM: optional zero-fill after
// reset, legality/alignment checking, store lane alignment and load extension.
module data_memory_lsu
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  output logic                  err_sticky,
  input  logic                  err_clr
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 2 ** WORD_AW;

  state_e              state_q, state_d;
  logic [WORD_AW-1:0]  clr_ptr_q;
  logic                fill_we_c;
  logic [WORD_AW-1:0]  word_c;
  logic [1:0]          lane_c;
  logic                accept_c, f3_ok_c, align_ok_c, legal_c, st_go_c, ld_go_c;
  logic [3:0]          bank_we_c;
  logic [WORD_AW-1:0]  bank_waddr_c;
  logic [31:0]         bank_wdata_c, bank_rdata, ld_shift_c, ld_ext_c;
  ld_ctx_t             ld_ctx_q;
  logic                ld_pend_q;
  logic [31:0]         rdata_hold_q;

  assign word_c   = req_addr[ADDR_WIDTH-1:2];
  assign lane_c   = req_addr[1:0];
  assign accept_c = req_valid & req_ready;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= CLEAR_ON_RESET ? ST_INIT : ST_RUN;
    else     state_q <= state_d;
  end

  // FSM next state: fill ends once the last word has been written
  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && clr_ptr_q == WORD_AW'(DEPTH - 1)) state_d = ST_RUN;
  end

  // FSM outputs
  always_comb begin
    req_ready = 1'b0;
    fill_we_c = 1'b0;
    case (state_q)
      ST_INIT: fill_we_c = ~rst;
      ST_RUN:  req_ready = ~rst;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)            clr_ptr_q <= '0;
    else if (fill_we_c) clr_ptr_q <= clr_ptr_q + WORD_AW'(1);
  end

  // Legality: supported funct3 for the direction, natural alignment for the size
  always_comb begin
    f3_ok_c    = 1'b0;
    align_ok_c = 1'b1;
    case (req_funct3)
      F3_B, F3_H, F3_W: f3_ok_c = 1'b1;
      F3_BU, F3_HU:     f3_ok_c = ~req_we;
      default:          f3_ok_c = 1'b0;
    endcase
    case (req_funct3[1:0])
      2'b01:   align_ok_c = ~lane_c[0];
      2'b10:   align_ok_c = (lane_c == 2'b00);
      default: align_ok_c = 1'b1;
    endcase
    legal_c = f3_ok_c & align_ok_c;
  end

  assign st_go_c = accept_c & req_we & legal_c;
  assign ld_go_c = accept_c & ~req_we & legal_c;

  // The fill sequence owns the write port while it runs
  always_comb begin
    bank_we_c    = 4'b0000;
    bank_waddr_c = word_c;
    bank_wdata_c = 32'(req_wdata << {lane_c, 3'b000});
    if (fill_we_c) begin
      bank_we_c    = 4'b1111;
      bank_waddr_c = clr_ptr_q;
      bank_wdata_c = '0;
    end else if (st_go_c) begin
      bank_we_c    = be_gen(req_funct3, lane_c);
    end
  end

  dmem_bank #(.WORD_AW(WORD_AW)) u_bank (
    .clk   (clk),
    .we    (bank_we_c),
    .waddr (bank_waddr_c),
    .wdata (bank_wdata_c),
    .re    (ld_go_c),
    .raddr (word_c),
    .rdata (bank_rdata)
  );

  // Load extraction and sign/zero extension
  always_comb begin
    ld_shift_c = bank_rdata >> {ld_ctx_q.lane, 3'b000};
    case (ld_ctx_q.funct3)
      F3_B:    ld_ext_c = {{24{ld_shift_c[7]}}, ld_shift_c[7:0]};
      F3_BU:   ld_ext_c = {24'h0, ld_shift_c[7:0]};
      F3_H:    ld_ext_c = {{16{ld_shift_c[15]}}, ld_shift_c[15:0]};
      F3_HU:   ld_ext_c = {16'h0, ld_shift_c[15:0]};
      default: ld_ext_c = ld_shift_c;
    endcase
  end

  always_ff @(posedge clk) begin
    if (ld_go_c) ld_ctx_q <= '{funct3: req_funct3, lane: lane_c};
  end

  // Response registers; rdata_hold_q keeps the last data once a load response ends
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      err_sticky   <= 1'b0;
      ld_pend_q    <= 1'b0;
      rdata_hold_q <= '0;
    end else begin
      rsp_valid  <= accept_c;
      ld_pend_q  <= ld_go_c;
      err_sticky <= (accept_c & ~legal_c) | (err_sticky & ~err_clr);
      if (accept_c) rsp_err <= ~legal_c;
      if (accept_c && !ld_go_c) rdata_hold_q <= '0;
      else if (ld_pend_q)       rdata_hold_q <= ld_ext_c;
    end
  end

  assign rsp_rdata = ld_pend_q ? DATA_WIDTH'(ld_ext_c) : DATA_WIDTH'(rdata_hold_q);

endmodule

// File: tb/tb_data_memory_lsu.sv
// Bench for data_memory_lsu: directed scenarios plus random traffic, checked
// against a byte-array memory model with per-cycle response expectations.
module tb_data_memory_lsu;

  localparam int unsigned AW    = 6;
  localparam int unsigned DEPTH = 16;

  logic          clk;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          err_sticky;
  logic          err_clr;

  data_memory_lsu #(
    .DATA_WIDTH     (32),
    .ADDR_WIDTH     (AW),
    .CLEAR_ON_RESET (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .err_sticky (err_sticky),
    .err_clr    (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks;
  int n_errors;

  logic [7:0]  mem_m [64];
  int          fill_cnt;
  bit          exp_valid, exp_err, exp_sticky;
  logic [31:0] exp_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return 2;
      2'b10:   return 4;
      default: return 1;
    endcase
  endfunction

  function automatic bit legal_m(input bit we, input logic [2:0] f3, input logic [AW-1:0] a);
    bit f3_ok;
    if (we) f3_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    f3_ok = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return f3_ok && (int'(a) % nbytes(f3) == 0);
  endfunction

  // One clock: check last cycle's response, drive this cycle, advance the model
  task automatic step(input bit r, input bit v, input bit we, input logic [2:0] f3,
                      input logic [AW-1:0] a, input logic [31:0] wd, input bit clr);
    bit          ready_m, ok, acc;
    int          n;
    logic [31:0] val;
    @(negedge clk);
    check("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("err_sticky", 32'(err_sticky), 32'(exp_sticky));
    check("rsp_rdata", rsp_rdata, exp_rdata);
    rst = r; req_valid = v; req_we = we; req_funct3 = f3;
    req_addr = a; req_wdata = wd; err_clr = clr;
    #1;
    ready_m = !r && (fill_cnt == DEPTH);
    check("req_ready", 32'(req_ready), 32'(ready_m));
    if (r) begin
      fill_cnt = 0; exp_valid = 0; exp_err = 0; exp_sticky = 0; exp_rdata = '0;
      for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;
    end else begin
      if (fill_cnt < DEPTH) fill_cnt++;
      acc = v && ready_m;
      ok  = legal_m(we, f3, a);
      exp_valid  = acc;
      exp_sticky = (acc && !ok) || (exp_sticky && !clr);
      if (acc) begin
        exp_err = !ok;
        n = nbytes(f3);
        if (!ok || we) exp_rdata = '0;
        if (ok && we) begin
          for (int i = 0; i < n; i++) mem_m[int'(a) + i] = wd[8*i +: 8];
        end else if (ok) begin
          val = '0;
          for (int i = 0; i < n; i++) val[8*i +: 8] = mem_m[int'(a) + i];
          if (!f3[2] && n == 1 && val[7])  val = val | 32'hFFFF_FF00;
          if (!f3[2] && n == 2 && val[15]) val = val | 32'hFFFF_0000;
          exp_rdata = val;
        end
      end
    end
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) step(0, 0, 0, 3'd0, '0, '0, 0);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    fill_cnt = 0; exp_valid = 0; exp_err = 0; exp_sticky = 0; exp_rdata = '0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = '0; req_wdata = '0; err_clr = 1'b0;
    for (int i = 0; i < 64; i++) mem_m[i] = 8'h00;

    // Reset, then fill; requests offered during the fill must be ignored
    repeat (3) step(1, 0, 0, 3'd0, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 1, 3'd2, 6'h3C, 32'hDEAD_BEEF, 0);
    step(0, 1, 0, 3'd2, 6'h3C, '0, 0);

    // Word store, then back-to-back loads of every width
    step(0, 1, 1, 3'd2, 6'h10, 32'h8081_8283, 0);
    step(0, 1, 0, 3'd0, 6'h10, '0, 0);
    step(0, 1, 0, 3'd4, 6'h11, '0, 0);
    step(0, 1, 0, 3'd1, 6'h12, '0, 0);
    step(0, 1, 0, 3'd5, 6'h12, '0, 0);
    step(0, 1, 0, 3'd2, 6'h10, '0, 0);

    // Byte store into the middle of a word, immediately read back
    step(0, 1, 1, 3'd2, 6'h20, 32'h1122_3344, 0);
    step(0, 1, 1, 3'd0, 6'h21, 32'h0000_00AA, 0);
    step(0, 1, 0, 3'd2, 6'h20, '0, 0);

    // Errors, err_clr colliding with a new error, then a clean clear
    step(0, 1, 1, 3'd1, 6'h23, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, 3'd2, 6'h02, '0, 0);
    step(0, 1, 0, 3'd3, 6'h20, '0, 1);
    step(0, 1, 0, 3'd2, 6'h20, '0, 0);
    step(0, 0, 0, 3'd0, '0, '0, 1);
    idle(1);

    // Top word of the address space
    step(0, 1, 1, 3'd2, 6'h3C, 32'hCAFE_F00D, 0);
    step(0, 1, 0, 3'd2, 6'h3C, '0, 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step(0, ($urandom % 4) != 0, $urandom % 2, 3'($urandom % 8), AW'($urandom),
           $urandom, ($urandom % 8) == 0);
    end

    // Reset in the middle of a fill with the error flag set
    step(0, 1, 0, 3'd7, 6'h00, '0, 0);
    step(1, 0, 0, 3'd0, '0, '0, 0);
    idle(5);
    step(1, 0, 0, 3'd0, '0, '0, 0);
    for (int i = 0; i < DEPTH; i++) step(0, 1, 0, 3'd2, 6'h08, '0, 0);
    step(0, 1, 0, 3'd2, 6'h10, '0, 0);
    step(0, 1, 0, 3'd1, 6'h22, '0, 0);
    idle(2);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
